id_exe_reg: RTL and testbench
=============================

# id_exe_reg

Pipeline register between the decode stage (register file plus control unit) and the execute stage of the 5-stage ARM core. It latches decoded control signals, operand values and instruction fields on every clock edge, and embeds a data-hazard detector. When a hazard is detected it inserts a bubble, signals upstream to stall, and counts stalls. It also obeys a global freeze from memory wait states and a flush from a taken branch.

## Interface
- `DW`, 32: data and PC width
- `RW`, 4: register-index width
- `CNTW`, 16: stall-counter width
- `clk` in 1: rising-edge clock
- `rst` in 1: reset, synchronous and active-high
- `freeze` in 1: global memory stall; hold all state
- `flush` in 1: branch taken in EXE; kill the instruction being latched
- `forward_en` in 1: forwarding unit present; only load-use hazards stall
- `in_valid` in 1: IF/ID slot holds a real instruction
- `exe_cmd_in` in 4, `mem_read_in`, `mem_write_in`, `wb_en_in`, `b_in`, `s_in`, `imm_in` in 1 each: control-unit outputs
- `pc_in` in DW; `val_rn_in`, `val_rm_in` in DW; `shift_operand_in` in 12; `signed_imm24_in` in 24
- `dest_in`, `src1_in`, `src2_in` in RW; `two_src` in 1: src2 is read (register operand or STR)
- `c_flag_in` in 1: carry bit from the status register
- `exe_dest`, `mem_dest` in RW; `exe_wb_en`, `mem_wb_en`, `exe_mem_read` in 1: downstream destination info
- `hazard` out 1: combinational; stalls the PC and IF/ID
- Outputs: matching `*_out` for every latched field (`exe_cmd_out` … `c_flag_out`, `src1_out`, `src2_out`), plus `valid_out` out 1
- `stall_count` out CNTW: saturating count of inserted hazard bubbles

## Operation
- Hazard logic is combinational and evaluated only when `in_valid`=1.
  - m1 = `src1_in`==`exe_dest` & `exe_wb_en`; suppressed when `b_in`.
  - m2 = `two_src` & `src2_in`==`exe_dest` & `exe_wb_en`.
  - n1, n2 are the same tests against `mem_dest` / `mem_wb_en`.
  - If `forward_en`=0: `hazard` = m1|m2|n1|n2.
  - If `forward_en`=1: `hazard` = `exe_mem_read` & (m1|m2).
- Register update, priority highest first:
  1. `rst`: all outputs go to 0, including `valid_out` and `stall_count`.
  2. `freeze`: all state is held; `flush` and `hazard` are ignored that cycle.
  3. `flush`: load a bubble.
  4. `hazard`: load a bubble and increment `stall_count`.
  5. Otherwise load all `*_in`; `valid_out` = `in_valid`.
- A bubble means `exe_cmd`, `mem_read`, `mem_write`, `wb_en`, `b`, `s` and `valid` are 0, and `dest`/`src` are 0. Datapath fields are don't-care; they are zeroed for determinism.
- A bubble never writes back, touches memory, branches or updates status.
- `stall_count` saturates at 2^CNTW−1 and never wraps.
- `hazard` is still driven during `freeze` and `flush`. Upstream gating is the caller's job.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Reset value of every output is 0.
- `hazard` depends combinationally on the current inputs, with no registered path.
- A stall lasts until the producer leaves the stage. Without forwarding, a dependency on EXE stalls 2 cycles and a dependency on MEM stalls 1.
- `flush` and `hazard` in the same cycle: flush wins; the counter does not increment.
- Reset asserted mid-freeze: reset wins.

## Structure
- The shared `defines` package already holds `EXECUTE_COMMAND_LEN` and `REG_INDEX_LEN`. Add `STALL_CNT_LEN` and a bubble-value constant there.
- Sub-module `hazard_detection_unit`, purely combinational, produces `hazard`. The id_exe_reg top holds the register bank and the counter.

## Test plan
- Reset: assert `rst` for 2 cycles with nonzero inputs → every output is 0 and `stall_count`=0.
- Pass-through: ADD with `exe_cmd_in`=ADD_EXE, `wb_en_in`=1, `dest_in`=3, `val_rn_in`=0x10 → the next cycle shows identical outputs and `valid_out`=1.
- Load-use: `forward_en`=1, `exe_mem_read`=1, `exe_dest`=5, `src1_in`=5 → `hazard`=1, the next cycle is a bubble, and `stall_count`=1. With `exe_mem_read`=0 → no stall.
- No forwarding: `forward_en`=0, `mem_dest`=2, `mem_wb_en`=1, `src2_in`=2, `two_src`=1 → bubble. The same case with `two_src`=0 → normal load.
- Freeze/flush priority: `freeze`=1 with `flush`=1 and `hazard`=1 for 3 cycles → outputs held and counter unchanged. Deassert `freeze` → a bubble loads and the counter is unchanged.
- Saturation: with CNTW=2, force 5 consecutive hazards → `stall_count` stops at 3.

Source files
------------

// File: rtl/id_exe_reg_pkg.sv
// Shared decode/execute definitions: field widths, execute commands, the
// control bundle carried through ID/EXE and its bubble value.
package id_exe_reg_pkg;

  localparam int EXECUTE_COMMAND_LEN = 4;
  localparam int REG_INDEX_LEN       = 4;
  localparam int STALL_CNT_LEN       = 16;
  localparam int SHIFT_OPERAND_LEN   = 12;
  localparam int SIGNED_IMM_LEN      = 24;

  // ALU command encodings produced by the control unit.
  typedef enum logic [EXECUTE_COMMAND_LEN-1:0] {
    EXE_NOP = 4'd0,
    EXE_MOV = 4'd1,
    EXE_ADD = 4'd2,
    EXE_ADC = 4'd3,
    EXE_SUB = 4'd4,
    EXE_SBC = 4'd5,
    EXE_AND = 4'd6,
    EXE_ORR = 4'd7,
    EXE_EOR = 4'd8,
    EXE_MVN = 4'd9
  } exe_cmd_e;

  // Control fields latched into EXE. Order is significant only for packing.
  typedef struct packed {
    logic [EXECUTE_COMMAND_LEN-1:0] exe_cmd;
    logic                           mem_read;
    logic                           mem_write;
    logic                           wb_en;
    logic                           b;
    logic                           s;
    logic                           imm;
  } ctrl_t;

  // A bubble has no side effects: no writeback, no memory access, no branch,
  // no status update.
  localparam ctrl_t BUBBLE_CTRL = '0;

  // True when a source register is about to be written by a downstream stage.
  function automatic logic reg_match(input logic [REG_INDEX_LEN-1:0] src,
                                     input logic [REG_INDEX_LEN-1:0] dest,
                                     input logic                     wb_en);
    return wb_en && (src == dest);
  endfunction

endpackage

// File: rtl/hazard_detection_unit.sv
// Combinational RAW hazard detector for the instruction sitting in IF/ID.
// Without forwarding any pending write to a source stalls; with forwarding
// only a load in EXE feeding a source stalls (load-use).
module hazard_detection_unit #(
  parameter int RW = 4
) (
  input  logic          i_in_valid,
  input  logic          i_forward_en,
  input  logic [RW-1:0] i_src1,
  input  logic [RW-1:0] i_src2,
  input  logic          i_two_src,
  input  logic          i_b,
  input  logic [RW-1:0] i_exe_dest,
  input  logic [RW-1:0] i_mem_dest,
  input  logic          i_exe_wb_en,
  input  logic          i_mem_wb_en,
  input  logic          i_exe_mem_read,
  output logic          o_hazard
);

  logic w_m1, w_m2, w_n1, w_n2;
  logic w_exe_dep, w_any_dep;

  // A branch does not read src1 as a register operand, so it never stalls on it.
  assign w_m1 = !i_b && (i_exe_wb_en && (i_src1 == i_exe_dest));
  assign w_m2 = i_two_src && (i_exe_wb_en && (i_src2 == i_exe_dest));
  assign w_n1 = !i_b && (i_mem_wb_en && (i_src1 == i_mem_dest));
  assign w_n2 = i_two_src && (i_mem_wb_en && (i_src2 == i_mem_dest));

  assign w_exe_dep = w_m1 | w_m2;
  assign w_any_dep = w_exe_dep | w_n1 | w_n2;

  // Forwarding covers everything except a value still being loaded in EXE.
  assign o_hazard = i_in_valid &&
                    (i_forward_en ? (i_exe_mem_read && w_exe_dep) : w_any_dep);

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with embedded hazard detection, bubble insertion
// and a saturating count of hazard bubbles. Freeze holds everything, flush
// kills the instruction being latched.
module id_exe_reg
  import id_exe_reg_pkg::*;
#(
  parameter int DW   = 32,
  parameter int RW   = 4,
  parameter int CNTW = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           freeze,
  input  logic                           flush,
  input  logic                           forward_en,
  input  logic                           in_valid,
  input  logic [EXECUTE_COMMAND_LEN-1:0] exe_cmd_in,
  input  logic                           mem_read_in,
  input  logic                           mem_write_in,
  input  logic                           wb_en_in,
  input  logic                           b_in,
  input  logic                           s_in,
  input  logic                           imm_in,
  input  logic [DW-1:0]                  pc_in,
  input  logic [DW-1:0]                  val_rn_in,
  input  logic [DW-1:0]                  val_rm_in,
  input  logic [SHIFT_OPERAND_LEN-1:0]   shift_operand_in,
  input  logic [SIGNED_IMM_LEN-1:0]      signed_imm24_in,
  input  logic [RW-1:0]                  dest_in,
  input  logic [RW-1:0]                  src1_in,
  input  logic [RW-1:0]                  src2_in,
  input  logic                           two_src,
  input  logic                           c_flag_in,
  input  logic [RW-1:0]                  exe_dest,
  input  logic [RW-1:0]                  mem_dest,
  input  logic                           exe_wb_en,
  input  logic                           mem_wb_en,
  input  logic                           exe_mem_read,
  output logic                           hazard,
  output logic [EXECUTE_COMMAND_LEN-1:0] exe_cmd_out,
  output logic                           mem_read_out,
  output logic                           mem_write_out,
  output logic                           wb_en_out,
  output logic                           b_out,
  output logic                           s_out,
  output logic                           imm_out,
  output logic [DW-1:0]                  pc_out,
  output logic [DW-1:0]                  val_rn_out,
  output logic [DW-1:0]                  val_rm_out,
  output logic [SHIFT_OPERAND_LEN-1:0]   shift_operand_out,
  output logic [SIGNED_IMM_LEN-1:0]      signed_imm24_out,
  output logic [RW-1:0]                  dest_out,
  output logic                           c_flag_out,
  output logic [RW-1:0]                  src1_out,
  output logic [RW-1:0]                  src2_out,
  output logic                           valid_out,
  output logic [CNTW-1:0]                stall_count
);

  // Everything besides the control bundle; zeroed in a bubble for determinism.
  typedef struct packed {
    logic [DW-1:0]                pc;
    logic [DW-1:0]                val_rn;
    logic [DW-1:0]                val_rm;
    logic [SHIFT_OPERAND_LEN-1:0] shift_operand;
    logic [SIGNED_IMM_LEN-1:0]    signed_imm24;
    logic [RW-1:0]                dest;
    logic [RW-1:0]                src1;
    logic [RW-1:0]                src2;
    logic                         c_flag;
    logic                         valid;
  } payload_t;

  ctrl_t     r_ctrl;
  payload_t  r_pay;
  logic [CNTW-1:0] r_cnt;

  ctrl_t     w_ctrl_in;
  payload_t  w_pay_in;
  logic      w_hazard;
  logic      w_bubble;
  logic      w_count;

  hazard_detection_unit #(.RW(RW)) u_hdu (
    .i_in_valid     (in_valid),
    .i_forward_en   (forward_en),
    .i_src1         (src1_in),
    .i_src2         (src2_in),
    .i_two_src      (two_src),
    .i_b            (b_in),
    .i_exe_dest     (exe_dest),
    .i_mem_dest     (mem_dest),
    .i_exe_wb_en    (exe_wb_en),
    .i_mem_wb_en    (mem_wb_en),
    .i_exe_mem_read (exe_mem_read),
    .o_hazard       (w_hazard)
  );

  // Hazard is exported unconditionally; gating against freeze/flush is upstream's job.
  assign hazard = w_hazard;

  assign w_ctrl_in = '{exe_cmd:   exe_cmd_in,
                       mem_read:  mem_read_in,
                       mem_write: mem_write_in,
                       wb_en:     wb_en_in,
                       b:         b_in,
                       s:         s_in,
                       imm:       imm_in};

  assign w_pay_in = '{pc:            pc_in,
                      val_rn:        val_rn_in,
                      val_rm:        val_rm_in,
                      shift_operand: shift_operand_in,
                      signed_imm24:  signed_imm24_in,
                      dest:          dest_in,
                      src1:          src1_in,
                      src2:          src2_in,
                      c_flag:        c_flag_in,
                      valid:         in_valid};

  // Flush outranks hazard, so a flushed cycle never counts as a stall.
  assign w_bubble = flush || w_hazard;
  assign w_count  = !flush && w_hazard && (r_cnt != {CNTW{1'b1}});

  // Pipeline register: reset > freeze (hold) > flush/hazard (bubble) > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= BUBBLE_CTRL;
      r_pay  <= '0;
      r_cnt  <= '0;
    end else if (!freeze) begin
      if (w_bubble) begin
        r_ctrl <= BUBBLE_CTRL;
        r_pay  <= '0;
      end else begin
        r_ctrl <= w_ctrl_in;
        r_pay  <= w_pay_in;
      end
      if (w_count) r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign exe_cmd_out       = r_ctrl.exe_cmd;
  assign mem_read_out      = r_ctrl.mem_read;
  assign mem_write_out     = r_ctrl.mem_write;
  assign wb_en_out         = r_ctrl.wb_en;
  assign b_out             = r_ctrl.b;
  assign s_out             = r_ctrl.s;
  assign imm_out           = r_ctrl.imm;
  assign pc_out            = r_pay.pc;
  assign val_rn_out        = r_pay.val_rn;
  assign val_rm_out        = r_pay.val_rm;
  assign shift_operand_out = r_pay.shift_operand;
  assign signed_imm24_out  = r_pay.signed_imm24;
  assign dest_out          = r_pay.dest;
  assign c_flag_out        = r_pay.c_flag;
  assign src1_out          = r_pay.src1;
  assign src2_out          = r_pay.src2;
  assign valid_out         = r_pay.valid;
  assign stall_count       = r_cnt;

endmodule

// File: tb/tb_id_exe_reg.sv
// Vector/scoreboard bench for id_exe_reg, built with a 2-bit stall counter so
// saturation is reachable.
module tb_id_exe_reg;
  import id_exe_reg_pkg::*;

  localparam int CNTW = 2;

  typedef struct packed {
    logic        in_valid;
    logic [3:0]  exe_cmd;
    logic        mem_read, mem_write, wb_en, b, s, imm;
    logic [31:0] pc, rn, rm;
    logic [11:0] shop;
    logic [23:0] imm24;
    logic [3:0]  dest, src1, src2;
    logic        two_src, c, fwd;
    logic [3:0]  exe_dest, mem_dest;
    logic        exe_wb_en, mem_wb_en, exe_mem_read;
  } in_t;

  typedef struct packed {
    logic [3:0]  exe_cmd;
    logic        mem_read, mem_write, wb_en, b, s, imm;
    logic [31:0] pc, rn, rm;
    logic [11:0] shop;
    logic [23:0] imm24;
    logic [3:0]  dest;
    logic        c;
    logic [3:0]  src1, src2;
    logic        valid;
    logic [CNTW-1:0] cnt;
  } out_t;

  typedef enum {K_LOAD, K_BUBBLE, K_HOLD, K_RESET} kind_e;

  typedef struct {
    in_t   in;
    bit    rst, frz, fl;
    bit    haz;
    kind_e kind;
    int    cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst, freeze, flush;
  in_t  cur;

  logic [3:0]  exe_cmd_out;
  logic        mem_read_out, mem_write_out, wb_en_out, b_out, s_out, imm_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [3:0]  dest_out, src1_out, src2_out;
  logic        c_flag_out, valid_out, hazard;
  logic [CNTW-1:0] stall_count;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];
  out_t sb[$];
  out_t last_exp;

  always #5 clk = ~clk;

  id_exe_reg #(.DW(32), .RW(4), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .forward_en(cur.fwd), .in_valid(cur.in_valid),
    .exe_cmd_in(cur.exe_cmd), .mem_read_in(cur.mem_read),
    .mem_write_in(cur.mem_write), .wb_en_in(cur.wb_en), .b_in(cur.b),
    .s_in(cur.s), .imm_in(cur.imm), .pc_in(cur.pc), .val_rn_in(cur.rn),
    .val_rm_in(cur.rm), .shift_operand_in(cur.shop),
    .signed_imm24_in(cur.imm24), .dest_in(cur.dest), .src1_in(cur.src1),
    .src2_in(cur.src2), .two_src(cur.two_src), .c_flag_in(cur.c),
    .exe_dest(cur.exe_dest), .mem_dest(cur.mem_dest),
    .exe_wb_en(cur.exe_wb_en), .mem_wb_en(cur.mem_wb_en),
    .exe_mem_read(cur.exe_mem_read), .hazard(hazard),
    .exe_cmd_out(exe_cmd_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .wb_en_out(wb_en_out), .b_out(b_out),
    .s_out(s_out), .imm_out(imm_out), .pc_out(pc_out),
    .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out),
    .signed_imm24_out(signed_imm24_out), .dest_out(dest_out),
    .c_flag_out(c_flag_out), .src1_out(src1_out), .src2_out(src2_out),
    .valid_out(valid_out), .stall_count(stall_count)
  );

  // ADD r3, r1, r2 with no downstream writers pending.
  function automatic in_t base_add(input logic [31:0] pc);
    in_t t;
    t = '0;
    t.in_valid = 1'b1;
    t.exe_cmd  = EXE_ADD;
    t.wb_en    = 1'b1;
    t.pc       = pc;
    t.rn       = 32'h10;
    t.rm       = 32'h2345_6789;
    t.shop     = 12'hA5C;
    t.imm24    = 24'h12_3456;
    t.dest     = 4'd3;
    t.src1     = 4'd1;
    t.src2     = 4'd2;
    t.c        = 1'b1;
    t.fwd      = 1'b1;
    t.exe_dest = 4'd9;
    t.mem_dest = 4'd10;
    return t;
  endfunction

  task automatic add_vec(input in_t in, input bit r, input bit fz, input bit fl,
                         input bit hz, input kind_e k, input int c);
    vec_t v;
    v.in = in; v.rst = r; v.frz = fz; v.fl = fl;
    v.haz = hz; v.kind = k; v.cnt = c;
    vecs.push_back(v);
  endtask

  function automatic out_t expect_of(input vec_t v);
    out_t e;
    e = '0;
    case (v.kind)
      K_LOAD: begin
        e.exe_cmd = v.in.exe_cmd; e.mem_read = v.in.mem_read;
        e.mem_write = v.in.mem_write; e.wb_en = v.in.wb_en; e.b = v.in.b;
        e.s = v.in.s; e.imm = v.in.imm; e.pc = v.in.pc; e.rn = v.in.rn;
        e.rm = v.in.rm; e.shop = v.in.shop; e.imm24 = v.in.imm24;
        e.dest = v.in.dest; e.c = v.in.c; e.src1 = v.in.src1;
        e.src2 = v.in.src2; e.valid = v.in.in_valid; e.cnt = CNTW'(v.cnt);
      end
      K_BUBBLE: e.cnt = CNTW'(v.cnt);
      K_HOLD:   e = last_exp;
      default:  e = '0;
    endcase
    return e;
  endfunction

  // Drive one vector, check hazard mid-cycle, check registered result after the edge.
  task automatic apply(input vec_t v, input int idx);
    out_t e, a;
    cur = v.in; rst = v.rst; freeze = v.frz; flush = v.fl;
    @(negedge clk);
    total++;
    if (hazard !== v.haz) begin
      bad++;
      $display("FAIL hazard[%0d]: got %b want %b", idx, hazard, v.haz);
    end
    e = expect_of(v);
    last_exp = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    a = '{exe_cmd_out, mem_read_out, mem_write_out, wb_en_out, b_out, s_out,
          imm_out, pc_out, val_rn_out, val_rm_out, shift_operand_out,
          signed_imm24_out, dest_out, c_flag_out, src1_out, src2_out,
          valid_out, stall_count};
    e = sb.pop_front();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL regs[%0d]: got %h want %h", idx, a, e);
    end
  endtask

  initial begin
    in_t t;
    cur = '0; rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    last_exp = '0;

    // Reset held two cycles with busy inputs.
    add_vec(base_add(32'h100), 1, 0, 0, 0, K_RESET, 0);
    add_vec(base_add(32'h104), 1, 0, 0, 0, K_RESET, 0);
    // Plain pass-through.
    add_vec(base_add(32'h0), 0, 0, 0, 0, K_LOAD, 0);
    // Load-use with forwarding.
    t = base_add(32'h8); t.src1 = 4'd5; t.exe_dest = 4'd5;
    t.exe_wb_en = 1'b1; t.exe_mem_read = 1'b1;
    add_vec(t, 0, 0, 0, 1, K_BUBBLE, 1);
    t.exe_mem_read = 1'b0;
    add_vec(t, 0, 0, 0, 0, K_LOAD, 1);
    // No forwarding, src2 against MEM.
    t = base_add(32'hC); t.fwd = 1'b0; t.src1 = 4'd7; t.src2 = 4'd2;
    t.mem_dest = 4'd2; t.mem_wb_en = 1'b1; t.two_src = 1'b1;
    add_vec(t, 0, 0, 0, 1, K_BUBBLE, 2);
    t.two_src = 1'b0;
    add_vec(t, 0, 0, 0, 0, K_LOAD, 2);
    // Branch does not depend on src1.
    t = base_add(32'h10); t.fwd = 1'b0; t.b = 1'b1; t.wb_en = 1'b0;
    t.exe_cmd = EXE_NOP; t.exe_dest = 4'd1; t.exe_wb_en = 1'b1;
    add_vec(t, 0, 0, 0, 0, K_LOAD, 2);
    // Invalid slot never stalls and latches valid=0.
    t = base_add(32'h14); t.fwd = 1'b0; t.in_valid = 1'b0;
    t.exe_dest = 4'd1; t.exe_wb_en = 1'b1;
    add_vec(t, 0, 0, 0, 0, K_LOAD, 2);
    // A real instruction to be held, then freeze with flush+hazard.
    t = base_add(32'h40); t.s = 1'b1; t.mem_write = 1'b1;
    add_vec(t, 0, 0, 0, 0, K_LOAD, 2);
    for (int i = 0; i < 3; i++) begin
      t = base_add(32'h44 + 32'(4 * i)); t.fwd = 1'b0;
      t.exe_dest = 4'd1; t.exe_wb_en = 1'b1;
      add_vec(t, 0, 1, 1, 1, K_HOLD, 2);
    end
    // Unfreeze: flush beats hazard, no count.
    add_vec(t, 0, 0, 1, 1, K_BUBBLE, 2);
    // Flush alone.
    add_vec(base_add(32'h60), 0, 0, 1, 0, K_BUBBLE, 2);
    // Reset during freeze.
    add_vec(base_add(32'h50), 0, 0, 0, 0, K_LOAD, 2);
    add_vec(base_add(32'h54), 1, 1, 0, 0, K_RESET, 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Saturation: five back-to-back hazards of different kinds on a 2-bit counter.
    t = base_add(32'h70); t.fwd = 1'b0; t.exe_dest = 4'd1; t.exe_wb_en = 1'b1;
    add_vec(t, 0, 0, 0, 1, K_BUBBLE, 1); apply(vecs[$], 100);
    t = base_add(32'h70); t.fwd = 1'b0; t.two_src = 1'b1;
    t.exe_dest = 4'd2; t.exe_wb_en = 1'b1;
    add_vec(t, 0, 0, 0, 1, K_BUBBLE, 2); apply(vecs[$], 101);
    t = base_add(32'h70); t.fwd = 1'b0; t.mem_dest = 4'd1; t.mem_wb_en = 1'b1;
    add_vec(t, 0, 0, 0, 1, K_BUBBLE, 3); apply(vecs[$], 102);
    t = base_add(32'h70); t.fwd = 1'b0; t.two_src = 1'b1;
    t.mem_dest = 4'd2; t.mem_wb_en = 1'b1;
    add_vec(t, 0, 0, 0, 1, K_BUBBLE, 3); apply(vecs[$], 103);
    t = base_add(32'h70); t.src2 = 4'd6; t.two_src = 1'b1;
    t.exe_dest = 4'd6; t.exe_wb_en = 1'b1; t.exe_mem_read = 1'b1;
    add_vec(t, 0, 0, 0, 1, K_BUBBLE, 3); apply(vecs[$], 104);
    // Stall released: the instruction finally loads, counter still saturated.
    t.exe_mem_read = 1'b0;
    add_vec(t, 0, 0, 0, 0, K_LOAD, 3); apply(vecs[$], 105);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
